clk_event_gen: RTL and testbench
================================

CLK_EVENT_GEN -- requirements
Module: clk_event_gen

Interface
REQ-001 Parameter COUNT_W, default 16; width of the half-period counters and config fields.
REQ-002 Parameter RESET_HIGH, default 1; active high-phase length after reset.
REQ-003 Parameter RESET_LOW, default 1; active low-phase length after reset.
REQ-004 sys_dom_i  input  common_p::clk_dom_s  one clock plus asynchronous, active-high reset (team clock-domain bundle); all logic on the rising edge of this clock.
REQ-005 generation_en_i  input  1  run request for the generated clock.
REQ-006 cfg_valid_i  input  1  new half-period pair offered.
REQ-007 cfg_high_i  input  COUNT_W  requested high-phase length in sys cycles.
REQ-008 cfg_low_i  input  COUNT_W  requested low-phase length in sys cycles.
REQ-009 cfg_ready_o  output  1  shadow slot free; cfg accepted when cfg_valid_i && cfg_ready_o.
REQ-010 clk_events_o  output  clks_alot_p::generated_events_s  fields rising (1-cycle pulse), falling (1-cycle pulse), level (generated clock level); feeds pause_control clk_events_i.
REQ-011 busy_o  output  1  high when FSM is not IDLE.

Function
REQ-012 FSM states IDLE, HIGH, LOW; all outputs registered.
REQ-013 IDLE -> HIGH on the cycle after generation_en_i is sampled 1; that cycle drives rising=1, level=1, counter loaded with active_high-1.
REQ-014 HIGH: counter decrements each cycle; when counter==0 and enabled, next cycle enters LOW with falling=1, level=0, counter loaded with active_low-1.
REQ-015 LOW: counter decrements; when counter==0 and enabled, next cycle enters HIGH with rising=1, level=1, counter loaded with active_high-1.
REQ-016 Level is high for exactly active_high cycles and low for exactly active_low cycles; period = active_high + active_low.
REQ-017 Config value 0 is treated as 1 (saturate); max value 2^COUNT_W-1 has no wrap.
REQ-018 Accepted cfg is stored in a shadow pair and sets pending; cfg_ready_o = !pending.
REQ-019 Pending pair copies to active only at a phase boundary that emits rising, or immediately (next cycle) while in IDLE; pending clears that same cycle.
REQ-020 Accept and apply in the same cycle is impossible (ready low while pending); no cfg is ever dropped or overwritten.
REQ-021 generation_en_i sampled 0 in HIGH: next cycle IDLE with falling=1, level=0 (clean low termination).
REQ-022 generation_en_i sampled 0 in LOW: next cycle IDLE, no event pulse, level=0.
REQ-023 rising and falling are never asserted in the same cycle; each is exactly 1 cycle wide.
REQ-024 Re-enable on the cycle after returning to IDLE restarts with a fresh full high phase (REQ-013).
REQ-025 busy_o = (state != IDLE).

Reset
REQ-026 Asynchronous assertion of reset forces IDLE, counter=0, active_high=RESET_HIGH, active_low=RESET_LOW, pending=0.
REQ-027 During and after reset: rising=0, falling=0, level=0, busy_o=0, cfg_ready_o=1.
REQ-028 Reset mid-phase discards pending cfg and emits no falling pulse; first cycle after deassertion behaves as IDLE.

Verification
REQ-029 Reset, cfg 2/3 accepted in IDLE, enable at cycle t -> rising at t+1, falling at t+3, rising at t+6, period 5 sustained.
REQ-030 Running 2/3, cfg 4/1 offered mid-HIGH -> cfg_ready_o drops, old 2/3 completes, new 4/1 applies at next rising; ready returns the following cycle.
REQ-031 cfg 0/0 then enable -> level toggles every cycle (treated 1/1), rising/falling alternate, never coincident.
REQ-032 Disable mid-HIGH -> one falling pulse next cycle, level=0, busy_o=0; disable mid-LOW -> no pulse.
REQ-033 Async reset asserted mid-LOW with cfg pending -> outputs 0 immediately, cfg_ready_o=1, active counts back to RESET_HIGH/RESET_LOW.
REQ-034 cfg 2^COUNT_W-1 high, 1 low -> high phase lasts exactly 65535 cycles (COUNT_W=16) with no wrap.

Source files
------------

// File: rtl/clk_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_event_gen
// Brief    : Programmable clock-event generator with shadowed half-period config
// Revision : 1.0
// ============================================================================
module clk_event_gen #(
    parameter int COUNT_W    = 16,
    parameter int RESET_HIGH = 1,
    parameter int RESET_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               generation_en_i,
    input  logic               cfg_valid_i,
    input  logic [COUNT_W-1:0] cfg_high_i,
    input  logic [COUNT_W-1:0] cfg_low_i,
    output logic               cfg_ready_o,
    output logic               clk_events_rising_o,
    output logic               clk_events_falling_o,
    output logic               clk_events_level_o,
    output logic               busy_o
);

    localparam logic [COUNT_W-1:0] c_one        = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_zero       = '0;
    localparam logic [COUNT_W-1:0] c_reset_high = (RESET_HIGH < 1) ? c_one : COUNT_W'(RESET_HIGH);
    localparam logic [COUNT_W-1:0] c_reset_low  = (RESET_LOW  < 1) ? c_one : COUNT_W'(RESET_LOW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t             r_state;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_active_high;
    logic [COUNT_W-1:0] r_active_low;
    logic [COUNT_W-1:0] r_shadow_high;
    logic [COUNT_W-1:0] r_shadow_low;
    logic               r_pending;
    logic               r_rising;
    logic               r_falling;
    logic               r_level;
    logic               r_busy;

    logic               w_accept;
    logic [COUNT_W-1:0] w_cfg_high_sat;
    logic [COUNT_W-1:0] w_cfg_low_sat;
    logic [COUNT_W-1:0] w_next_high;
    logic [COUNT_W-1:0] w_next_low;

    // Zero-length phases are stored as one so the counter never underflows.
    assign w_cfg_high_sat = (cfg_high_i == c_zero) ? c_one : cfg_high_i;
    assign w_cfg_low_sat  = (cfg_low_i  == c_zero) ? c_one : cfg_low_i;
    assign w_accept       = cfg_valid_i && !r_pending;
    assign w_next_high    = r_pending ? r_shadow_high : r_active_high;
    assign w_next_low     = r_pending ? r_shadow_low  : r_active_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_count       <= c_zero;
            r_active_high <= c_reset_high;
            r_active_low  <= c_reset_low;
            r_shadow_high <= c_reset_high;
            r_shadow_low  <= c_reset_low;
            r_pending     <= 1'b0;
            r_rising      <= 1'b0;
            r_falling     <= 1'b0;
            r_level       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rising  <= 1'b0;
            r_falling <= 1'b0;

            // Accept only when the shadow is empty; apply only when it is full.
            if (w_accept) begin
                r_shadow_high <= w_cfg_high_sat;
                r_shadow_low  <= w_cfg_low_sat;
                r_pending     <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_level <= 1'b0;
                    if (r_pending) begin
                        r_active_high <= r_shadow_high;
                        r_active_low  <= r_shadow_low;
                        r_pending     <= 1'b0;
                    end
                    if (generation_en_i) begin
                        r_state  <= ST_HIGH;
                        r_rising <= 1'b1;
                        r_level  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_count  <= w_next_high - c_one;
                    end
                end
                ST_HIGH: begin
                    if (!generation_en_i) begin
                        r_state   <= ST_IDLE;
                        r_falling <= 1'b1;
                        r_level   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_count   <= c_zero;
                    end else if (r_count == c_zero) begin
                        r_state   <= ST_LOW;
                        r_falling <= 1'b1;
                        r_level   <= 1'b0;
                        r_count   <= r_active_low - c_one;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                ST_LOW: begin
                    if (!generation_en_i) begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                        r_busy  <= 1'b0;
                        r_count <= c_zero;
                    end else if (r_count == c_zero) begin
                        r_state  <= ST_HIGH;
                        r_rising <= 1'b1;
                        r_level  <= 1'b1;
                        r_count  <= w_next_high - c_one;
                        if (r_pending) begin
                            r_active_high <= r_shadow_high;
                            r_active_low  <= w_next_low;
                            r_pending     <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                    r_count <= c_zero;
                end
            endcase
        end
    end

    assign cfg_ready_o          = !r_pending;
    assign clk_events_rising_o  = r_rising;
    assign clk_events_falling_o = r_falling;
    assign clk_events_level_o   = r_level;
    assign busy_o               = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_clk_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_event_gen
// Brief    : Directed vector table plus multi-cycle sequences for clk_event_gen
// Revision : 1.0
// ============================================================================
module tb_clk_event_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid;
    logic [15:0] cfg_high;
    logic [15:0] cfg_low;
    logic        ready;
    logic        rising;
    logic        falling;
    logic        level;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    clk_event_gen #(
        .COUNT_W    (16),
        .RESET_HIGH (1),
        .RESET_LOW  (1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .generation_en_i      (en),
        .cfg_valid_i          (valid),
        .cfg_high_i           (cfg_high),
        .cfg_low_i            (cfg_low),
        .cfg_ready_o          (ready),
        .clk_events_rising_o  (rising),
        .clk_events_falling_o (falling),
        .clk_events_level_o   (level),
        .busy_o               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        valid;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        r;
        logic        f;
        logic        lv;
        logic        b;
        logic        rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic r, input logic f, input logic lv,
                           input logic b, input logic rd);
        chk({name, "_rising"},  {31'd0, rising},  {31'd0, r});
        chk({name, "_falling"}, {31'd0, falling}, {31'd0, f});
        chk({name, "_level"},   {31'd0, level},   {31'd0, lv});
        chk({name, "_busy"},    {31'd0, busy},    {31'd0, b});
        chk({name, "_ready"},   {31'd0, ready},   {31'd0, rd});
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; valid = 1'b0; cfg_high = '0; cfg_low = '0;
        tick();
        tick();
        chk_out("in_reset", 0, 0, 0, 0, 1);
        rst = 1'b0;
    endtask

    task automatic offer(input logic [15:0] h, input logic [15:0] l);
        valid = 1'b1; cfg_high = h; cfg_low = l;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        int cnt;
        // en, valid, hi, lo, rising, falling, level, busy, ready
        vecs.push_back('{0, 1, 16'd2, 16'd3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 16'd0, 16'd0, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 1, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 1, 0, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 0, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 0, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 1, 0, 1, 1, 1});
        vecs.push_back('{1, 1, 16'd4, 16'd1, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 1, 0, 1, 0});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 1, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 1, 0, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 1, 0, 1, 1, 1});
        vecs.push_back('{0, 0, 16'd0, 16'd0, 0, 1, 0, 0, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 1, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 1, 0, 1, 1});
        vecs.push_back('{0, 0, 16'd0, 16'd0, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 1, 0, 1, 1, 1});
        vecs.push_back('{1, 0, 16'd0, 16'd0, 0, 0, 1, 1, 1});

        do_reset();
        chk_out("after_reset", 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; valid = vecs[i].valid;
            cfg_high = vecs[i].hi; cfg_low = vecs[i].lo;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].f, vecs[i].lv, vecs[i].b, vecs[i].rd);
        end

        // Zero config saturates to 1/1: level toggles every cycle.
        do_reset();
        offer(16'd0, 16'd0);
        tick();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_out($sformatf("zero_cfg%0d", i), (i % 2) == 0, (i % 2) == 1, (i % 2) == 0, 1, 1);
            chk($sformatf("zero_cfg%0d_coincident", i), {31'd0, rising & falling}, 32'd0);
        end

        // Async reset mid-LOW with a pending pair discards it.
        do_reset();
        offer(16'd2, 16'd3);
        tick();
        en = 1'b1;
        tick(); tick(); tick(); tick();
        chk_out("pre_areset_low", 0, 0, 0, 1, 1);
        offer(16'd5, 16'd5);
        chk_out("pre_areset_pending", 0, 0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk_out("areset_immediate", 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
        tick();
        chk_out("areset_restart_rise", 1, 0, 1, 1, 1);
        tick();
        chk_out("areset_default_high", 0, 1, 0, 1, 1);
        tick();
        chk_out("areset_default_low", 1, 0, 1, 1, 1);

        // Maximum high phase: no counter wrap.
        do_reset();
        offer(16'hFFFF, 16'd1);
        tick();
        en = 1'b1;
        tick();
        chk_out("max_rise", 1, 0, 1, 1, 1);
        cnt = 0;
        while (level === 1'b1 && cnt < 70000) begin
            cnt++;
            tick();
        end
        chk("max_high_len", cnt, 32'd65535);
        chk_out("max_fall", 0, 1, 0, 1, 1);
        tick();
        chk_out("max_low_one", 1, 0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
